seven_seg_scan: RTL and testbench

- Sequencer for the 4-digit multiplexed seven-segment display.
- Accepts a 14-bit binary value through a load handshake.
- Converts the value to four BCD digits with a sequential shift-add-3 (double dabble) engine.
- Time-multiplexes the digits onto the shared seg/an lines at a parameterised refresh rate.
- Sits between the application logic and the board display pins.

---
 rtl/seven_seg_if.sv | 11 +
 rtl/seven_seg_scan.sv | 118 +++++++++++
 tb/tb_seven_seg_scan.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_if.sv
// seven_seg_if: load handshake and display pins shared by seven_seg_scan and its driver.
interface seven_seg_if;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        overflow;
    logic [7:0]  seg;
    logic [3:0]  an;
    modport master (output value, load, input busy, overflow, seg, an);
    modport slave  (input value, load, output busy, overflow, seg, an);
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: double-dabble BCD conversion of a loaded value and 4-digit multiplexed scan.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading-zero digit positions.
module seven_seg_scan #(
    parameter int REFRESH_CNT = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    seven_seg_if.slave bus
);
    localparam int CW = REFRESH_CNT > 1 ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CNT - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    state_t        state_q, state_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d, bcd_adj;
    logic [3:0]    shift_q, shift_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   dig_q, dig_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pos_q, pos_d;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          blank;

    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'h3F;
            4'd1:    decode = 8'h06;
            4'd2:    decode = 8'h5B;
            4'd3:    decode = 8'h4F;
            4'd4:    decode = 8'h66;
            4'd5:    decode = 8'h6D;
            4'd6:    decode = 8'h7D;
            4'd7:    decode = 8'h07;
            4'd8:    decode = 8'h7F;
            4'd9:    decode = 8'h6F;
            default: decode = 8'h00;
        endcase
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        shift_d = shift_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        case (state_q)
            IDLE: if (bus.load) begin
                state_d = CONV;
                ovf_d   = bus.value > 14'd9999;
                bin_d   = ovf_d ? 14'd9999 : bus.value;
                bcd_d   = '0;
                shift_d = '0;
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                shift_d        = shift_q + 4'd1;
                state_d        = shift_q == 4'd13 ? COMMIT : CONV;
            end
            COMMIT: begin
                dig_d   = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A position is a leading zero when it and every higher digit are zero.
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    assign blank = pos_q != 2'd0 && (dig_q >> (4 * pos_q)) == 16'd0;
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q == CNT_MAX ? '0 : cnt_q + CW'(1);
        pos_d = cnt_q == CNT_MAX ? pos_q + 2'd1 : pos_q;
        an_d  = blank ? 4'b1111 : ~(4'b0001 << pos_q);
        seg_d = blank ? 8'h00 : decode(dig_q[4*pos_q +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            seg_q   <= 8'h00;
            an_q    <= 4'b1111;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.busy     = state_q != IDLE;
    assign bus.overflow = ovf_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: random loads against a cycle-level arithmetic model of conversion and scan.
// Honours SEVEN_SEG_LEADING_ZERO_BLANK_EN when defined for the build.
module tb_seven_seg_scan;
    localparam int R = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    seven_seg_if bus();
    seven_seg_scan #(.REFRESH_CNT(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] lut [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    function automatic logic [7:0] seg_of(input int d);
        return (d >= 0 && d < 10) ? lut[d] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n counts edges since reset release, k is the edge of the last accepted load.
    int n = 0;
    int k = -1000;
    int m_dig [4] = '{0, 0, 0, 0};
    int pend [4] = '{0, 0, 0, 0};
    logic m_ovf = 1'b0;

    always @(posedge clk) begin
        int p, v;
        logic bl;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic e_busy;
        if (!rst_n) begin
            n = 0;
            k = -1000;
            m_ovf = 1'b0;
            m_dig = '{0, 0, 0, 0};
            #1;
            check("rst_seg", bus.seg, 8'h00);
            check("rst_an", bus.an, 4'b1111);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_ovf", bus.overflow, 1'b0);
        end else begin
            n++;
            p = ((n - 1) / R) % 4;
            bl = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            bl = p > 0;
            for (int i = p; i < 4; i++) if (m_dig[i] != 0) bl = 1'b0;
`endif
            e_an  = bl ? 4'b1111 : ~(4'b0001 << p);
            e_seg = bl ? 8'h00 : seg_of(m_dig[p]);
            if (n - k == 15) m_dig = pend;
            if (bus.load && !(n - 1 - k >= 0 && n - 1 - k < 15)) begin
                k = n;
                v = bus.value > 9999 ? 9999 : int'(bus.value);
                m_ovf = bus.value > 9999;
                pend[0] = v % 10;
                pend[1] = (v / 10) % 10;
                pend[2] = (v / 100) % 10;
                pend[3] = v / 1000;
            end
            e_busy = n - k >= 0 && n - k < 15;
            #1;
            check("busy", bus.busy, e_busy);
            check("overflow", bus.overflow, m_ovf);
            check("an", bus.an, e_an);
            check("seg", bus.seg, e_seg);
        end
    end

    task automatic do_load(input int v);
        @(negedge clk);
        bus.value = 14'(v);
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (bus.busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", bus.busy, 1'b0);
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int c = 0;
        @(negedge clk);
        while (bus.an !== pat && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("an_timeout", bus.an, pat);
    endtask

    initial begin
        int c;
        bus.load  = 1'b0;
        bus.value = '0;
        repeat (3) @(negedge clk);
        check("lit_rst_seg", bus.seg, 8'h00);
        check("lit_rst_an", bus.an, 4'b1111);
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_first_an", bus.an, 4'b1110);
        check("lit_first_seg", bus.seg, 8'h3F);

        do_load(1234);
        c = 0;
        while (bus.busy && c < 40) begin
            c++;
            @(negedge clk);
        end
        check("lit_busy_len", 16'(c), 16'd15);
        wait_an(4'b1110);
        check("lit_1234_d0", bus.seg, 8'h66);
        wait_an(4'b1101);
        check("lit_1234_d1", bus.seg, 8'h4F);
        wait_an(4'b0111);
        check("lit_1234_d3", bus.seg, 8'h06);

        do_load(12000);
        wait_idle();
        check("lit_ovf_set", bus.overflow, 1'b1);
        wait_an(4'b1110);
        check("lit_sat_d0", bus.seg, 8'h6F);

        do_load(5);
        wait_idle();
        check("lit_ovf_clr", bus.overflow, 1'b0);
        wait_an(4'b1110);
        check("lit_5_d0", bus.seg, 8'h6D);

        do_load(4321);
        repeat (4) @(negedge clk);
        do_load(9999);
        wait_idle();
        wait_an(4'b1110);
        check("lit_ignored", bus.seg, 8'h06);
        do_load(9999);
        check("lit_accept", bus.busy, 1'b1);
        wait_idle();
        wait_an(4'b1110);
        check("lit_9999_d0", bus.seg, 8'h6F);

        do_load(8888);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("lit_abort_an", bus.an, 4'b1111);
        check("lit_abort_busy", bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("lit_abort_seg", bus.seg, 8'h3F);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        do_load(7);
        wait_idle();
        wait_an(4'b1110);
        check("lit_blank7_d0", bus.seg, 8'h07);
        c = 0;
        repeat (16) begin
            @(negedge clk);
            if (bus.an != 4'b1110 && bus.an != 4'b1111) c++;
        end
        check("lit_blank7_lit", 16'(c), 16'd0);
        do_load(0);
        wait_idle();
        wait_an(4'b1110);
        check("lit_blank0_d0", bus.seg, 8'h3F);
`endif

        repeat (40) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            do_load(int'($urandom_range(0, 16383)));
        end
        repeat (100) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
